// File: rtl/feeder_pkg.sv
// Shared constants, state encoding and helpers for the west-edge skew feeder.
package feeder_pkg;

    localparam int LANE_W = 9;
    localparam int DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic int clog2(input int v);
        int w;
        w = 0;
        while ((1 << w) < v) w++;
        return w;
    endfunction

endpackage

// File: rtl/west_skew_feeder_if.sv
// Vector-push, stream-command and west-lane bundle between the feeder and its neighbours.
interface west_skew_feeder_if #(
    parameter int ROWS  = 4,
    parameter int LEN_W = 8
);
    import feeder_pkg::*;

    logic [ROWS*DATA_W-1:0] i_vec;
    logic                   i_vec_valid;
    logic                   o_vec_ready;
    logic                   i_start;
    logic [LEN_W-1:0]       i_len;
    logic [ROWS*LANE_W-1:0] o_west;
    logic                   o_busy;
    logic                   o_done;

    modport slave (
        input  i_vec, i_vec_valid, i_start, i_len,
        output o_vec_ready, o_west, o_busy, o_done
    );

    modport master (
        output i_vec, i_vec_valid, i_start, i_len,
        input  o_vec_ready, o_west, o_busy, o_done
    );

endinterface

// File: rtl/row_vec_fifo.sv
// Row-vector FIFO with wrap-bit pointers and registered full/empty flags; no write-through.
module row_vec_fifo
    import feeder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_wr_nxt;
    logic [AW:0]      w_rd_nxt;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;
    assign w_wr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_do_push};
    assign w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_do_pop};

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Flags are computed from the next pointers so they are valid right after the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                        (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
            r_empty  <= (w_wr_nxt == w_rd_nxt);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/west_skew_feeder.sv
// Buffers row vectors and streams them into the PE array west edge with per-row systolic skew.
//
//  state  | meaning
//  IDLE   | waiting for i_start; pushes still accepted
//  STREAM | pop one vector per cycle when available, bubble otherwise
//  DRAIN  | ROWS cycles of lane-0 bubbles while the skew chains empty
//  DONE   | one cycle; o_done pulses on the following cycle
module west_skew_feeder
    import feeder_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    west_skew_feeder_if.slave bus
);

    localparam int DR_W = clog2(ROWS + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_W-1:0]       r_remaining;
    logic [DR_W-1:0]        r_drain;
    logic                   r_done;
    logic [ROWS*LANE_W-1:0] r_cap;
    logic [ROWS*LANE_W-1:0] w_west;
    logic [ROWS*DATA_W-1:0] w_rdata;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;

    assign w_push = bus.i_vec_valid && !w_full;
    assign w_pop  = (r_state == ST_STREAM) && !w_empty;

    row_vec_fifo #(
        .WIDTH (ROWS*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (bus.i_vec),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.i_start) w_state_nxt = (bus.i_len == '0) ? ST_DONE : ST_STREAM;
            ST_STREAM: if (w_pop && (r_remaining == LEN_W'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (r_drain == '0) w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // o_done is registered off DONE so it lands one edge after the state visit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_drain     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ST_DONE);
            if ((r_state == ST_IDLE) && bus.i_start) r_remaining <= bus.i_len;
            else if (w_pop)                          r_remaining <= r_remaining - LEN_W'(1);
            if (r_state == ST_STREAM)                       r_drain <= DR_W'(ROWS - 1);
            else if ((r_state == ST_DRAIN) && (r_drain != '0)) r_drain <= r_drain - DR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                r_cap[i*LANE_W +: LANE_W] <= w_pop ? {1'b1, w_rdata[i*DATA_W +: DATA_W]}
                                                   : {LANE_W{1'b0}};
            end
        end
    end

    assign w_west[0 +: LANE_W] = r_cap[0 +: LANE_W];

    for (genvar r = 1; r < ROWS; r++) begin : g_lane
        logic [LANE_W-1:0] r_sh [r];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int k = 0; k < r; k++) r_sh[k] <= '0;
            end else begin
                r_sh[0] <= r_cap[r*LANE_W +: LANE_W];
                for (int k = 1; k < r; k++) r_sh[k] <= r_sh[k-1];
            end
        end

        assign w_west[r*LANE_W +: LANE_W] = r_sh[r-1];
    end

    assign bus.o_west      = w_west;
    assign bus.o_vec_ready = !w_full;
    assign bus.o_busy      = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
    assign bus.o_done      = r_done;

endmodule

// File: tb/tb_west_skew_feeder.sv
// Self-checking bench for west_skew_feeder: directed table, corner sequences and a random run.
module tb_west_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DEPTH = 8;
    localparam int LEN_W = 8;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    west_skew_feeder_if #(.ROWS(ROWS), .LEN_W(LEN_W)) bus ();

    west_skew_feeder #(.ROWS(ROWS), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    // Reference model: FIFO contents as a queue, lane outputs scheduled by edge number.
    logic [31:0] mq[$];
    logic [8:0]  sched [64][ROWS];
    bit          m_str;
    int          m_rem;
    int          m_done_edge;
    int          m_idle_from;
    int          m_acc;
    int          l0_edges[$];
    int          done_edges[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 64; i++)
            for (int r = 0; r < ROWS; r++) sched[i][r] = '0;
        m_str       = 1'b0;
        m_rem       = 0;
        m_done_edge = -100;
        m_idle_from = 0;
    endtask

    task automatic model_edge();
        int  pre;
        bit  push_ok;
        bit  pop;
        logic [31:0] v;
        pre     = mq.size();
        push_ok = bus.i_vec_valid && (pre < DEPTH);
        pop     = m_str && (pre > 0);
        if (!m_str && (n >= m_idle_from) && bus.i_start) begin
            if (bus.i_len == 0) begin
                m_done_edge = n + 1;
                m_idle_from = n + 2;
            end else begin
                m_str = 1'b1;
                m_rem = int'(bus.i_len);
            end
        end
        if (pop) begin
            v = mq.pop_front();
            for (int r = 0; r < ROWS; r++) sched[(n + r) % 64][r] = {1'b1, v[r*8 +: 8]};
            m_rem--;
            if (m_rem == 0) begin
                m_str       = 1'b0;
                m_done_edge = n + ROWS + 1;
                m_idle_from = m_done_edge + 1;
            end
        end
        if (push_ok) begin
            mq.push_back(bus.i_vec);
            m_acc++;
        end
    endtask

    task automatic model_check();
        logic [35:0] ew;
        for (int r = 0; r < ROWS; r++) ew[r*9 +: 9] = sched[n % 64][r];
        chk("west", bus.o_west, ew);
        chk("busy", bus.o_busy, m_str || (n < m_done_edge - 1));
        chk("done", bus.o_done, n == m_done_edge);
        chk("ready", bus.o_vec_ready, mq.size() < DEPTH);
        for (int r = 0; r < ROWS; r++) sched[n % 64][r] = '0;
        if (bus.o_west[8]) l0_edges.push_back(n);
        if (bus.o_done)    done_edges.push_back(n);
    endtask

    task automatic cycle();
        @(posedge i_clk);
        n++;
        model_edge();
        #1;
        model_check();
    endtask

    task automatic idle_in();
        bus.i_vec_valid = 1'b0;
        bus.i_vec       = '0;
        bus.i_start     = 1'b0;
        bus.i_len       = '0;
    endtask

    task automatic push_in(input logic [31:0] v);
        bus.i_vec_valid = 1'b1;
        bus.i_vec       = v;
    endtask

    typedef struct {
        logic        vv;
        logic [31:0] vec;
        logic        st;
        logic [7:0]  len;
        logic [35:0] west;
        logic        busy;
        logic        done;
        logic        ready;
    } vec_t;

    vec_t tv [9];

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d actual=timeout required=finish", n);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        tv[0] = '{1'b1, 32'h04030201, 1'b0, 8'd0, 36'h0,            1'b0, 1'b0, 1'b1};
        tv[1] = '{1'b0, 32'h0,        1'b1, 8'd1, 36'h0,            1'b1, 1'b0, 1'b1};
        tv[2] = '{1'b0, 32'h0,        1'b0, 8'd0, 36'h101,          1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b0, 32'h0,        1'b0, 8'd0, (36'h102 << 9),   1'b1, 1'b0, 1'b1};
        tv[4] = '{1'b0, 32'h0,        1'b0, 8'd0, (36'h103 << 18),  1'b1, 1'b0, 1'b1};
        tv[5] = '{1'b0, 32'h0,        1'b0, 8'd0, (36'h104 << 27),  1'b1, 1'b0, 1'b1};
        tv[6] = '{1'b0, 32'h0,        1'b0, 8'd0, 36'h0,            1'b0, 1'b0, 1'b1};
        tv[7] = '{1'b0, 32'h0,        1'b0, 8'd0, 36'h0,            1'b0, 1'b1, 1'b1};
        tv[8] = '{1'b0, 32'h0,        1'b0, 8'd0, 36'h0,            1'b0, 1'b0, 1'b1};

        idle_in();
        model_reset();
        m_acc = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_west", bus.o_west, 36'h0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_ready", bus.o_vec_ready, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single vector through the skew chain, table driven.
        for (int i = 0; i < 9; i++) begin
            bus.i_vec_valid = tv[i].vv;
            bus.i_vec       = tv[i].vec;
            bus.i_start     = tv[i].st;
            bus.i_len       = tv[i].len;
            cycle();
            chk("t2_west", bus.o_west, tv[i].west);
            chk("t2_busy", bus.o_busy, tv[i].busy);
            chk("t2_done", bus.o_done, tv[i].done);
            chk("t2_ready", bus.o_vec_ready, tv[i].ready);
        end
        idle_in();
        cycle();

        // Back-to-back: three preloaded vectors stream without bubbles.
        for (int i = 0; i < 3; i++) begin push_in($urandom); cycle(); end
        idle_in();
        cycle();
        l0_edges.delete(); done_edges.delete();
        bus.i_start = 1'b1; bus.i_len = 8'd3;
        cycle();
        idle_in();
        repeat (12) cycle();
        chk("t3_count", l0_edges.size(), 3);
        if (l0_edges.size() == 3) begin
            chk("t3_consec", l0_edges[2] - l0_edges[0], 2);
            chk("t3_done_at", (done_edges.size() > 0) ? done_edges[0] : -1, l0_edges[2] + ROWS + 1);
        end

        // Underflow: second vector arrives late, bubbles in between.
        l0_edges.delete(); done_edges.delete();
        bus.i_start = 1'b1; bus.i_len = 8'd2;
        push_in($urandom);
        cycle();
        idle_in();
        repeat (4) cycle();
        push_in($urandom);
        cycle();
        idle_in();
        repeat (10) cycle();
        chk("t4_count", l0_edges.size(), 2);
        if (l0_edges.size() == 2) begin
            chk("t4_gap", l0_edges[1] - l0_edges[0], 5);
            chk("t4_done_at", (done_edges.size() > 0) ? done_edges[0] : -1, l0_edges[1] + ROWS + 1);
        end

        // Full FIFO, push/pop at full, pointer wrap over 3*DEPTH vectors.
        m_acc = 0;
        for (int i = 0; i < DEPTH; i++) begin push_in($urandom); cycle(); end
        chk("t5_full_ready", bus.o_vec_ready, 1'b0);
        push_in($urandom);
        cycle();
        chk("t5_full_hold", mq.size(), DEPTH);
        l0_edges.delete(); done_edges.delete();
        for (int k = 0; k < 80; k++) begin
            bus.i_start     = (k == 0);
            bus.i_len       = 8'(3 * DEPTH);
            bus.i_vec_valid = (m_acc < 3 * DEPTH);
            bus.i_vec       = $urandom;
            cycle();
        end
        idle_in();
        chk("t5_count", l0_edges.size(), 3 * DEPTH);
        if (l0_edges.size() == 3 * DEPTH)
            chk("t5_consec", l0_edges[3*DEPTH-1] - l0_edges[0], 3 * DEPTH - 1);
        chk("t5_empty", bus.o_vec_ready, 1'b1);

        // Zero length: done two edges after the start is applied, no valid lanes.
        l0_edges.delete(); done_edges.delete();
        bus.i_start = 1'b1; bus.i_len = 8'd0;
        cycle();
        s = n;
        idle_in();
        repeat (4) cycle();
        chk("t6_zero_done", (done_edges.size() == 1) ? done_edges[0] : -1, s + 1);
        chk("t6_zero_valid", l0_edges.size(), 0);

        // Start during STREAM is ignored; the original length of 3 stands.
        l0_edges.delete(); done_edges.delete();
        push_in($urandom);
        cycle();
        idle_in();
        bus.i_start = 1'b1; bus.i_len = 8'd3;
        cycle();
        bus.i_len = 8'd1;
        repeat (3) cycle();
        idle_in();
        push_in($urandom); cycle();
        push_in($urandom); cycle();
        idle_in();
        repeat (10) cycle();
        chk("t6_ign_count", l0_edges.size(), 3);
        if (l0_edges.size() == 3)
            chk("t6_ign_done", (done_edges.size() == 1) ? done_edges[0] : -1, l0_edges[2] + ROWS + 1);

        // Mid-stream reset: outputs clear asynchronously, FIFO ends up empty, no done.
        for (int i = 0; i < 3; i++) begin push_in($urandom); cycle(); end
        idle_in();
        bus.i_start = 1'b1; bus.i_len = 8'd3;
        cycle();
        idle_in();
        repeat (2) cycle();
        done_edges.delete(); l0_edges.delete();
        #2 i_rst_n = 1'b0;
        #1;
        chk("t1_west", bus.o_west, 36'h0);
        chk("t1_busy", bus.o_busy, 1'b0);
        chk("t1_ready", bus.o_vec_ready, 1'b1);
        chk("t1_done", bus.o_done, 1'b0);
        model_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        bus.i_start = 1'b1; bus.i_len = 8'd1;
        cycle();
        idle_in();
        repeat (4) cycle();
        chk("t1_fifo_empty", l0_edges.size(), 0);
        chk("t1_no_done", done_edges.size(), 0);
        push_in($urandom);
        cycle();
        idle_in();
        repeat (8) cycle();
        chk("t1_recover_done", done_edges.size(), 1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            bus.i_vec_valid = 1'($urandom_range(0, 1));
            bus.i_vec       = $urandom;
            bus.i_start     = ($urandom_range(0, 9) == 0);
            bus.i_len       = 8'($urandom_range(0, 5));
            cycle();
        end
        idle_in();
        for (int k = 0; k < 60; k++) begin
            bus.i_vec_valid = m_str;
            bus.i_vec       = $urandom;
            cycle();
        end
        chk("final_idle", bus.o_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
